rng: RTL and testbench
======================

// Module: rng
// PURPOSE
// - Pseudo-random request generator for the elevator controller. Produces a
//   12-bit random vector each clock, one bit per floor call button.
// - Feeds simulated floor presses into the request logic.
// - Fully deterministic from SEED, so benches can compare against a golden
//   per-cycle sequence (12-bit hex words, one per cycle).
// PARAMETERS
// - WIDTH  12             output width in bits; one bit per floor; 1..16
// - SEED   32'h1234_5ACE  LFSR reset value; if 0, 32'h0000_0001 is used instead
// - MASK   12'hFFF        per-bit output enable; bits cleared here are always 0
// PORTS
// - clk    in   1      single clock, rising-edge
// - rst    in   1      reset, synchronous, active-low; sampled on rising clk
// - randy  out  WIDTH  registered pseudo-random vector
// BEHAVIOUR
// - State: 32-bit Fibonacci LFSR s[31:0], maximal length (period 2^32-1).
// - Polynomial: x^32+x^22+x^2+x^1+1.
// - Next state: s_next = {s[30:0], s[31]^s[21]^s[1]^s[0]}.
// - Reset: on a rising clk edge with rst==0:
//   - s <= SEED, or 32'h1 when SEED==0.
//   - randy <= 0.
// - Run: on each rising clk edge with rst==1:
//   - s <= s_next.
//   - randy <= out(s) & MASK, where out(s) = s[WIDTH-1:0].
//   - out() is evaluated on the pre-update state.
// - Latency:
//   - First edge after reset release: randy = SEED[WIDTH-1:0] & MASK.
//   - Each later edge: the low bits of each successive state.
//   - One new word per clock; no stall, no handshake.
// - Lock-up guard: if s==0 at a run edge (corruption/X recovery), s <= 32'h1.
//   - randy still updates from the current s on that edge.
// - Reset mid-operation: the next edge with rst==0 reloads the seed and zeroes
//   randy, regardless of state.
//   - Sequence restarts identically after every reset.
// - No X propagation: all state is reset; there are no combinational outputs.
// CONFIGURATION
// - RNG_DENSITY_EN defined:
//   - out(s) = s[WIDTH-1:0] & s[WIDTH+11:12].
//   - Gives roughly 25% per-bit press density, i.e. fewer simultaneous calls.
//   - State update, reset and latency are unchanged.
// - RNG_DENSITY_EN undefined: out(s) = s[WIDTH-1:0], roughly 50% density.
// TESTING
// - Reset:
//   - Stimulus: hold rst=0 for 2 edges.
//   - Response: randy==12'h000 after the first edge and on every edge while
//     rst=0.
// - Golden sequence (defaults, no macro):
//   - Stimulus: release rst.
//   - Response: randy==12'hACE after edge 1, 12'h59C after edge 2.
//   - Next 8 words match the software model of s_next.
// - Density (RNG_DENSITY_EN):
//   - Stimulus: release rst with defaults.
//   - Response: first randy==12'h244 (12'hACE & 12'h345).
// - Mid-run reset:
//   - Stimulus: run 37 cycles, pull rst=0 for 1 edge, release.
//   - Response: randy==0 after the reset edge, then 12'hACE, 12'h59C again.
// - Mask and zero seed:
//   - Stimulus: MASK=12'h0F0, SEED=0; release rst.
//   - Response: first randy==12'h000.
//   - Over 1000 cycles randy & 12'hF0F stays 0.
//   - The LFSR never reaches 0.

Source files
------------

// File: rtl/rng.sv
// rng: pseudo-random floor-call generator for the elevator controller.
// A 32-bit Fibonacci LFSR (x^32+x^22+x^2+x^1+1) advances every clock. The low
// WIDTH bits of the pre-update state, gated by MASK, are registered onto randy.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-low reset (reloads seed, clears randy)
//   randy  out  WIDTH  registered pseudo-random vector, one bit per floor
//
// Parameters:
//   WIDTH  output width, 1..16
//   SEED   LFSR reset value; 0 is replaced by 32'h1
//   MASK   per-bit output enable
//
// Build option:
//   RNG_DENSITY_EN  when defined, each output bit is the AND of two state bits
//                   (s[WIDTH-1:0] & s[WIDTH+11:12]), for ~25% press density.
module rng #(
  parameter int unsigned      WIDTH = 12,
  parameter logic [31:0]      SEED  = 32'h1234_5ACE,
  parameter logic [WIDTH-1:0] MASK  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] randy
);

  localparam int unsigned STATE_W = 32;
  // A zero seed would lock the LFSR, so substitute the smallest legal state.
  localparam logic [STATE_W-1:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [STATE_W-1:0] s;
  logic [STATE_W-1:0] s_next_c;
  logic               fb_c;
  logic [WIDTH-1:0]   out_c;

  // Feedback taps at 32, 22, 2, 1 (bit indices 31, 21, 1, 0).
  always_comb begin
    fb_c     = 1'b0;
    s_next_c = s;
    fb_c     = s[31] ^ s[21] ^ s[1] ^ s[0];
    s_next_c = {s[30:0], fb_c};
  end

  // Output word from the current (pre-update) state.
  always_comb begin
    out_c = '0;
`ifdef RNG_DENSITY_EN
    out_c = s[WIDTH-1:0] & s[WIDTH+11:12];
`else
    out_c = s[WIDTH-1:0];
`endif
  end

  // State and output registers; all-zero state is steered back to 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s     <= SEED_EFF;
      randy <= '0;
    end else begin
      randy <= out_c & MASK;
      if (s == '0) begin
        s <= STATE_W'(1);
      end else begin
        s <= s_next_c;
      end
    end
  end

endmodule

// File: tb/tb_rng.sv
// tb_rng: self-checking bench for rng. Two instances run side by side: one
// with default parameters, one with SEED=0 and MASK=12'h0F0. Expected words
// come from a behavioural LFSR model kept in the bench.
module tb_rng;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic [11:0] randy_a;
  logic [11:0] randy_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rng u_a (
    .clk   (clk),
    .rst   (rst_a),
    .randy (randy_a)
  );

  rng #(
    .WIDTH (12),
    .SEED  (32'h0),
    .MASK  (12'h0F0)
  ) u_b (
    .clk   (clk),
    .rst   (rst_b),
    .randy (randy_b)
  );

  // Tap positions of x^32+x^22+x^2+x^1+1 as a bit set.
  localparam logic [31:0] TAPS = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;

`ifdef RNG_DENSITY_EN
  localparam logic [11:0] EXP_FIRST  = 12'h244;
  localparam logic [11:0] EXP_SECOND = 12'h488;
`else
  localparam logic [11:0] EXP_FIRST  = 12'hACE;
  localparam logic [11:0] EXP_SECOND = 12'h59C;
`endif

  // Reference model state/expected outputs for each instance.
  logic [31:0] ma, mb;
  logic [11:0] ea, eb;

  function automatic logic [31:0] model_next(input logic [31:0] st);
    logic [31:0] nx;
    if (st == 32'd0) return 32'd1;
    nx = st * 2;                       // shift left, MSB drops off
    nx[0] = ^(st & TAPS);              // parity of the tapped bits
    return nx;
  endfunction

  function automatic logic [11:0] model_out(input logic [31:0] st, input logic [11:0] msk);
    logic [11:0] w;
    w = st[11:0];
`ifdef RNG_DENSITY_EN
    w = w & st[23:12];
`endif
    return w & msk;
  endfunction

  // Drive both resets, advance one edge, update the models, settle past edge.
  task automatic step(input logic ra, input logic rb);
    rst_a = ra;
    rst_b = rb;
    @(posedge clk);
    if (!ra) begin ma = 32'h1234_5ACE; ea = 12'h000; end
    else begin ea = model_out(ma, 12'hFFF); ma = model_next(ma); end
    if (!rb) begin mb = 32'h0000_0001; eb = 12'h000; end
    else begin eb = model_out(mb, 12'h0F0); mb = model_next(mb); end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      vectors++;
      if (randy_a !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_a edge %0d: got %h want 000", i, randy_a);
      end
      vectors++;
      if (randy_b !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_b edge %0d: got %h want 000", i, randy_b);
      end
    end
  endtask

  task automatic test_golden();
    step(1'b1, 1'b0);
    vectors++;
    if (randy_a !== EXP_FIRST) begin
      miscompares++;
      $display("FAIL golden_w1: got %h want %h", randy_a, EXP_FIRST);
    end
    step(1'b1, 1'b0);
    vectors++;
    if (randy_a !== EXP_SECOND) begin
      miscompares++;
      $display("FAIL golden_w2: got %h want %h", randy_a, EXP_SECOND);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if (randy_a !== ea) begin
        miscompares++;
        $display("FAIL golden_w%0d: got %h want %h", i + 3, randy_a, ea);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 37; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if (randy_a !== ea) begin
        miscompares++;
        $display("FAIL mid_run cycle %0d: got %h want %h", i, randy_a, ea);
      end
    end
    step(1'b0, 1'b0);
    vectors++;
    if (randy_a !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_reset_edge: got %h want 000", randy_a);
    end
    step(1'b1, 1'b0);
    vectors++;
    if (randy_a !== EXP_FIRST) begin
      miscompares++;
      $display("FAIL mid_restart_w1: got %h want %h", randy_a, EXP_FIRST);
    end
    step(1'b1, 1'b0);
    vectors++;
    if (randy_a !== EXP_SECOND) begin
      miscompares++;
      $display("FAIL mid_restart_w2: got %h want %h", randy_a, EXP_SECOND);
    end
  endtask

  task automatic test_mask_zero_seed();
    int bad_mask = 0;
    int bad_seq  = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    vectors++;
    if (randy_b !== 12'h000) begin
      miscompares++;
      $display("FAIL zero_seed_w1: got %h want 000", randy_b);
    end
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1);
      vectors++;
      if ((randy_b & 12'hF0F) !== 12'h000) begin
        miscompares++;
        if (bad_mask < 5)
          $display("FAIL mask_bits cycle %0d: got %h want bits F0F clear", i, randy_b);
        bad_mask++;
      end
      vectors++;
      if (randy_b !== eb) begin
        miscompares++;
        if (bad_seq < 5)
          $display("FAIL zero_seed_seq cycle %0d: got %h want %h", i, randy_b, eb);
        bad_seq++;
      end
    end
  endtask

  // Random reset pulses on both instances, every word checked against the model.
  task automatic test_random_resets();
    logic ra, rb;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 19) != 0);
      rb = ($urandom_range(0, 19) != 0);
      step(ra, rb);
      vectors++;
      if (randy_a !== ea) begin
        miscompares++;
        if (bad < 5) $display("FAIL rand_a cycle %0d: got %h want %h", i, randy_a, ea);
        bad++;
      end
      vectors++;
      if (randy_b !== eb) begin
        miscompares++;
        if (bad < 5) $display("FAIL rand_b cycle %0d: got %h want %h", i, randy_b, eb);
        bad++;
      end
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ma = '0; mb = '0; ea = '0; eb = '0;
    test_reset();
    test_golden();
    test_mid_reset();
    test_mask_zero_seed();
    test_random_resets();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
